// File: rtl/jump_resolve_unit.sv
// Jump resolve unit: four-state sequential jump/branch resolver.
// Captures a request, classifies it, evaluates, and returns a registered result.
module jump_resolve_unit #(
  parameter int PC_W    = 16,
  parameter int INS_W   = 16,
  parameter int OPC_MSB = 15,
  parameter int OPC_LSB = 11,
  parameter int OFF_W   = 8,
  parameter logic [OPC_MSB-OPC_LSB:0] OP_J    = 5'b10000,
  parameter logic [OPC_MSB-OPC_LSB:0] OP_JAL  = 5'b10001,
  parameter logic [OPC_MSB-OPC_LSB:0] OP_BEQZ = 5'b10010,
  parameter logic [OPC_MSB-OPC_LSB:0] OP_BNEZ = 5'b10011,
  parameter logic [OPC_MSB-OPC_LSB:0] OP_JR   = 5'b10100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [INS_W-1:0] ins,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  rs_val,
  input  logic             abort,
  output logic [1:0]       jump,
  output logic             res_valid,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             link_we,
  output logic [PC_W-1:0]  link_val
);

  localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EVAL,
    DONE
  } state_t;

  state_t state;

  logic [INS_W-1:0] ins_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  rs_q;

  logic [PC_W-1:0]  tgt_q;
  logic             ld_q;
  logic             lnk_q;
  logic             load_r;
  logic             link_r;
  logic             res_q;

  logic             accept;
  logic [OPC_W-1:0] opc;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  abs_tgt;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  br_tgt;
  logic             is_abs;
  logic             is_br;
  logic             is_jr;
  logic             taken;

  logic [1:0]       cls;
  logic [PC_W-1:0]  tgt;
  logic             ld;
  logic             lnk;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !abort;

  assign opc     = ins_q[OPC_MSB:OPC_LSB];
  assign pc_inc  = pc_q + PC_ONE;
  assign abs_tgt = {pc_q[PC_W-1:OPC_LSB], ins_q[OPC_LSB-1:0]};
  assign off_ext = {{(PC_W-OFF_W){ins_q[OFF_W-1]}},
                    ins_q[OFF_W-1:0]};
  assign br_tgt  = pc_q + PC_ONE + off_ext;

  assign is_abs = (opc == OP_J) || (opc == OP_JAL);
  assign is_br  = (opc == OP_BEQZ) || (opc == OP_BNEZ);
  assign is_jr  = (opc == OP_JR);
  assign taken  = (opc == OP_BEQZ) ? (rs_q == '0)
                                   : (rs_q != '0);

  // A flush in the result cycle must suppress the pulse immediately.
  assign res_valid = res_q & ~abort;
  assign pc_load   = load_r & res_valid;
  assign link_we   = link_r & res_valid;

  // Classify the captured instruction and pick its successor PC.
  always_comb begin
    cls = 2'b00;
    tgt = pc_inc;
    ld  = 1'b0;
    lnk = 1'b0;
    unique case (1'b1)
      is_abs: begin
        cls = 2'b01;
        tgt = abs_tgt;
        ld  = 1'b1;
        lnk = (opc == OP_JAL);
      end
      is_br: begin
        cls = 2'b10;
        if (taken) begin
          tgt = br_tgt;
          ld  = 1'b1;
        end
      end
      is_jr: begin
        cls = 2'b11;
        tgt = rs_q;
        ld  = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the request operands on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_q <= '0;
      pc_q  <= '0;
      rs_q  <= '0;
    end else if (accept) begin
      ins_q <= ins;
      pc_q  <= pc;
      rs_q  <= rs_val;
    end
  end

  // Control FSM with registered class and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      jump      <= 2'b00;
      tgt_q     <= '0;
      ld_q      <= 1'b0;
      lnk_q     <= 1'b0;
      pc_target <= '0;
      link_val  <= '0;
      load_r    <= 1'b0;
      link_r    <= 1'b0;
      res_q     <= 1'b0;
    end else if (abort && state != IDLE) begin
      state  <= IDLE;
      jump   <= 2'b00;
      load_r <= 1'b0;
      link_r <= 1'b0;
      res_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= DECODE;
        end
        DECODE: begin
          jump  <= cls;
          tgt_q <= tgt;
          ld_q  <= ld;
          lnk_q <= lnk;
          state <= EVAL;
        end
        EVAL: begin
          pc_target <= tgt_q;
          link_val  <= pc_inc;
          load_r    <= ld_q;
          link_r    <= lnk_q;
          res_q     <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          load_r <= 1'b0;
          link_r <= 1'b0;
          res_q  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
